// File: rtl/add_sched_pkg.sv
// Shared types and defaults for the round-robin add scheduler.
// Imported by the interface, the scheduler and its testbench.
package add_sched_pkg;

  localparam int WIDTH_DEF = 6;
  localparam int NREQ_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_sched_if.sv
// Request/result bundle between requesters, consumer and add_sched.
// master = requester/consumer side, slave = scheduler side.
interface add_sched_if
  import add_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) ();

  localparam int IDW = idw(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_sum;
  logic                  res_overflow;
  logic [IDW-1:0]        res_id;

  modport master (
    output req, a_in, b_in, res_ready,
    input  gnt, res_valid, res_sum,
    input  res_overflow, res_id
  );

  modport slave (
    input  req, a_in, b_in, res_ready,
    output gnt, res_valid, res_sum,
    output res_overflow, res_id
  );

endinterface

// File: rtl/add_core.sv
// Combinational WIDTH-bit ripple-carry adder built from full-adder cells.
// Carry-in is fixed at zero.
module add_core #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  logic [WIDTH:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i])
                   | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[WIDTH];

endmodule

// File: rtl/add_sched.sv
// Round-robin scheduler feeding one shared adder.
// Grants one requester per IDLE visit, holds the result until accepted.
module add_sched
  import add_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic clk,
  input  logic rst_n,
  add_sched_if.slave bus
);

  localparam int IDW = idw(NREQ);

  state_t           state;
  state_t           nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic             found;
  logic             grant;
  logic             load;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic [NREQ-1:0]  gnt_q;
  logic             valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             ovf_q;
  logic [IDW-1:0]   id_q;

  // First asserted request at or above ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req[(int'(ptr) + i) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  assign sel_a = bus.a_in[int'(win)*WIDTH +: WIDTH];
  assign sel_b = bus.b_in[int'(win)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt    = state;
    grant  = 1'b0;
    load   = 1'b0;
    accept = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant = 1'b1;
          nxt   = ADD;
        end
      end
      ADD: begin
        load = 1'b1;
        nxt  = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          accept = 1'b1;
          nxt    = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      gnt_q   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      gnt_q <= '0;
      if (grant) begin
        gnt_q[win] <= 1'b1;
        op_a       <= sel_a;
        op_b       <= sel_b;
        id_q       <= win;
        ptr        <= (win == IDW'(NREQ-1))
                    ? '0 : win + 1'b1;
      end
      if (load) begin
        sum_q   <= sum;
        ovf_q   <= co;
        valid_q <= 1'b1;
      end
      if (accept) valid_q <= 1'b0;
    end
  end

  add_core #(
    .WIDTH(WIDTH)
  ) u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (sum),
    .co  (co)
  );

  assign bus.gnt          = gnt_q;
  assign bus.res_valid    = valid_q;
  assign bus.res_sum      = sum_q;
  assign bus.res_overflow = ovf_q;
  assign bus.res_id       = id_q;

endmodule

// File: doc/add_sched.md
ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, the operand and result width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, the number of requesters; IDW = clog2(NREQ).
REQ-003 clk  input  1  the block's one clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester add request, level; held until the matching gnt bit is seen.
REQ-006 a_in  input  NREQ*WIDTH  operand A; slice i belongs to requester i, stable while req[i]=1.
REQ-007 b_in  input  NREQ*WIDTH  operand B; same slicing and stability rule as a_in.
REQ-008 gnt  output  NREQ  one-hot single-cycle pulse: the operands of requester i have been captured.
REQ-009 res_valid  output  1  result is available.
REQ-010 res_ready  input  1  consumer accepts the result.
REQ-011 res_sum  output  WIDTH  unsigned sum modulo 2^WIDTH.
REQ-012 res_overflow  output  1  carry out of the MSB.
REQ-013 res_id  output  IDW  index of the requester that owns the result.

Function
REQ-014 The FSM SHALL have three states: IDLE, ADD and DONE.
REQ-015 IDLE with req != 0 at edge k SHALL select a winner round-robin, searching upward from ptr and wrapping.
- At edge k: capture the winner's operands into op_a/op_b and its index into res_id.
- At edge k: set ptr = (winner+1) mod NREQ and move to ADD.
- gnt[winner] SHALL be high for exactly cycle k+1.
REQ-016 IDLE with req == 0 SHALL stay in IDLE with all outputs unchanged.
REQ-017 ADD at edge k+1 SHALL register res_sum and res_overflow from op_a + op_b and move to DONE.
- res_valid SHALL be 1 from cycle k+2.
REQ-018 DONE SHALL hold res_valid, res_sum, res_overflow and res_id stable while res_ready=0.
REQ-019 DONE with res_ready=1 at an edge SHALL clear res_valid and return to IDLE.
- A pending req SHALL be granted no earlier than the following edge.
- Minimum issue interval is therefore 3 cycles.
REQ-020 The block SHALL NOT sample req or assert gnt in ADD or DONE.
REQ-021 With several simultaneous requests, exactly one SHALL be granted per IDLE visit.
- The loser's req stays asserted and is served on a later IDLE visit in round-robin order.
REQ-022 The addition SHALL be WIDTH-bit unsigned: res_sum = (a+b) mod 2^WIDTH and res_overflow = (a+b) >= 2^WIDTH.
REQ-023 The addition SHALL have no carry-in.
REQ-024 ptr SHALL wrap from NREQ-1 to 0.

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, ptr 0, gnt 0, res_valid 0, res_sum 0, res_overflow 0, res_id 0, op_a/op_b 0.
REQ-026 Reset asserted in ADD or DONE SHALL discard the in-flight operation.
- No res_valid follows release.
- Arbitration restarts from requester 0.
REQ-027 The first grant is possible at the first rising edge after rst_n is released.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, ADD, DONE) and the WIDTH and NREQ defaults.
REQ-029 The adder SHALL be one instantiated sub-module, add_core.
- Combinational WIDTH-bit ripple carry of full-adder cells.
- Carry-in tied 0; outputs sum and carry-out.
REQ-030 Arbitration, FSM and result registers SHALL reside in add_sched.

Verification (WIDTH=6, NREQ=4)
REQ-031 Single request: req[0]=1, a=5, b=7.
- gnt=0001 one cycle after capture.
- res_sum=12, res_overflow=0, res_id=0, res_valid two cycles after capture.
REQ-032 Overflow: req[2]=1, a=63, b=1.
- res_sum=0, res_overflow=1, res_id=2.
- Also check a=32, b=32 gives sum=0, overflow=1.
REQ-033 Fairness: req=1111 after reset, each requester dropping req after its gnt, res_ready=1.
- Grant order 0,1,2,3.
- Then req=1001 gives order 0,3.
REQ-034 Backpressure: hold res_ready=0 for 5 cycles in DONE while req=0010.
- res_valid and the result stay stable, gnt stays 0.
- gnt=0010 is issued on the second edge after res_ready=1.
REQ-035 Reset mid-operation: drop rst_n during ADD.
- gnt and res_valid are 0 immediately, and no result appears after release.
- With req=1111 the next grant goes to requester 0.
